// File: rtl/bpred_sdp_ram.sv
// bpred_sdp_ram: mixed-width simple dual-port RAM, one write and one read port.
// Registered read (one cycle), read-during-write returns old data.
module bpred_sdp_ram #(
  parameter int WR_DATA_W = 32,
  parameter int WR_ADDR_W = 8,
  parameter int RD_DATA_W = 2,
  parameter int RD_ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wren,
  input  logic [WR_ADDR_W-1:0] wraddress,
  input  logic [WR_DATA_W-1:0] data,
  input  logic [RD_ADDR_W-1:0] rdaddress,
  output logic [RD_DATA_W-1:0] q
);

  localparam int TOTAL = WR_DATA_W * (2 ** WR_ADDR_W);
  localparam int RD_TOTAL = RD_DATA_W * (2 ** RD_ADDR_W);
  localparam int BIG = (WR_DATA_W > RD_DATA_W) ? WR_DATA_W : RD_DATA_W;
  localparam int SMALL = (WR_DATA_W > RD_DATA_W) ? RD_DATA_W : WR_DATA_W;
  localparam int RATIO = BIG / SMALL;
  localparam int IDX_W = (TOTAL > 2) ? $clog2(TOTAL) : 1;

  // Both ports must view the same bit array, split by a power-of-two ratio.
  if (TOTAL != RD_TOTAL) begin : g_size_err
    $error("bpred_sdp_ram: write and read port sizes differ");
  end

  if ((BIG % SMALL) != 0 || (RATIO & (RATIO - 1)) != 0) begin : g_ratio_err
    $error("bpred_sdp_ram: width ratio is not a power of two");
  end

  // Flat storage; word W of either port is the slice [W*width +: width],
  // which gives lane 0 in the LSBs for narrow reads and lowest address
  // in the LSBs for wide reads.
  logic [TOTAL-1:0] mem = '0;

  logic [IDX_W-1:0] wr_lo;
  logic [IDX_W-1:0] rd_lo;

  assign wr_lo = IDX_W'(wraddress) * IDX_W'(WR_DATA_W);
  assign rd_lo = IDX_W'(rdaddress) * IDX_W'(RD_DATA_W);

  // Write port: not gated by reset so tables can be loaded during reset.
  always_ff @(posedge clk) begin
    if (wren) begin
      mem[wr_lo +: WR_DATA_W] <= data;
    end
  end

  // Read port: registered, samples pre-write contents on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= mem[rd_lo +: RD_DATA_W];
    end
  end

endmodule

// File: tb/tb_bpred_sdp_ram.sv
// tb_bpred_sdp_ram: checks default, equal-width and wide-read configs.
// Expected read data is queued when a read is issued and popped after the edge.
module tb_bpred_sdp_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_wren;
  logic [7:0]  a_wa;
  logic [31:0] a_d;
  logic [11:0] a_ra;
  logic [1:0]  a_q;

  logic        b_wren;
  logic [7:0]  b_wa;
  logic [31:0] b_d;
  logic [7:0]  b_ra;
  logic [31:0] b_q;

  logic        c_wren;
  logic [3:0]  c_wa;
  logic [3:0]  c_d;
  logic [0:0]  c_ra;
  logic [31:0] c_q;

  bpred_sdp_ram u_a (
    .clk(clk), .reset(reset), .wren(a_wren), .wraddress(a_wa),
    .data(a_d), .rdaddress(a_ra), .q(a_q)
  );

  bpred_sdp_ram #(
    .WR_DATA_W(32), .WR_ADDR_W(8), .RD_DATA_W(32), .RD_ADDR_W(8)
  ) u_b (
    .clk(clk), .reset(reset), .wren(b_wren), .wraddress(b_wa),
    .data(b_d), .rdaddress(b_ra), .q(b_q)
  );

  bpred_sdp_ram #(
    .WR_DATA_W(4), .WR_ADDR_W(4), .RD_DATA_W(32), .RD_ADDR_W(1)
  ) u_c (
    .clk(clk), .reset(reset), .wren(c_wren), .wraddress(c_wa),
    .data(c_d), .rdaddress(c_ra), .q(c_q)
  );

  typedef struct {
    string       name;
    int          unit;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];

  typedef struct {
    string       name;
    logic        wren;
    logic [7:0]  wa;
    logic [31:0] d;
    logic [11:0] ra;
    logic        chk;
    logic [1:0]  exp;
  } vec_t;

  localparam int NV = 13;
  vec_t vt[NV];

  int n_run = 0;
  int n_fail = 0;

  task automatic expect_q(input string name, input int unit,
                          input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.unit = unit;
    e.exp = exp;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] get_q(input int unit);
    case (unit)
      0: return {30'b0, a_q};
      1: return b_q;
      default: return c_q;
    endcase
  endfunction

  task automatic tick();
    sb_t e;
    logic [31:0] act;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = get_q(e.unit);
      n_run++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
    a_wren = 1'b0;
    b_wren = 1'b0;
    c_wren = 1'b0;
  endtask

  initial begin
    vt[0]  = '{"pwrup_zero", 1'b1, 8'h05, 32'hE4E4_1B1B, 12'h000, 1'b1, 2'b00};
    vt[1]  = '{"lane0",  1'b0, 8'h00, 32'h0, 12'h050, 1'b1, 2'b11};
    vt[2]  = '{"lane1",  1'b0, 8'h00, 32'h0, 12'h051, 1'b1, 2'b10};
    vt[3]  = '{"lane2",  1'b0, 8'h00, 32'h0, 12'h052, 1'b1, 2'b01};
    vt[4]  = '{"lane3",  1'b0, 8'h00, 32'h0, 12'h053, 1'b1, 2'b00};
    vt[5]  = '{"lane8",  1'b0, 8'h00, 32'h0, 12'h058, 1'b1, 2'b00};
    vt[6]  = '{"lane9",  1'b0, 8'h00, 32'h0, 12'h059, 1'b1, 2'b01};
    vt[7]  = '{"lane10", 1'b0, 8'h00, 32'h0, 12'h05A, 1'b1, 2'b10};
    vt[8]  = '{"lane11", 1'b0, 8'h00, 32'h0, 12'h05B, 1'b1, 2'b11};
    vt[9]  = '{"disjoint_wr", 1'b1, 8'h06, 32'hFFFF_FFFF, 12'h050, 1'b1, 2'b11};
    vt[10] = '{"other_word",  1'b0, 8'h00, 32'h0, 12'h060, 1'b1, 2'b11};
    vt[11] = '{"rdw_old", 1'b1, 8'h07, 32'hFFFF_FFFF, 12'h070, 1'b1, 2'b00};
    vt[12] = '{"rdw_new", 1'b0, 8'h00, 32'h0, 12'h070, 1'b1, 2'b11};

    reset = 1'b1;
    a_wren = 1'b0; a_wa = '0; a_d = '0; a_ra = '0;
    b_wren = 1'b0; b_wa = '0; b_d = '0; b_ra = '0;
    c_wren = 1'b0; c_wa = '0; c_d = '0; c_ra = '0;
    #1;

    // Reset state of all three configurations.
    expect_q("rst_a", 0, 32'h0);
    expect_q("rst_b", 1, 32'h0);
    expect_q("rst_c", 2, 32'h0);
    tick();
    reset = 1'b0;

    // Default config vectors.
    for (int i = 0; i < NV; i++) begin
      a_wren = vt[i].wren;
      a_wa = vt[i].wa;
      a_d = vt[i].d;
      a_ra = vt[i].ra;
      if (vt[i].chk) expect_q(vt[i].name, 0, {30'b0, vt[i].exp});
      tick();
    end

    // Reset clears q only; a write during reset still lands.
    reset = 1'b1;
    a_ra = 12'h050;
    a_wren = 1'b1; a_wa = 8'h00; a_d = 32'hAAAA_AAAA;
    expect_q("rst_q_zero", 0, 32'h0);
    tick();
    reset = 1'b0;
    a_ra = 12'h050;
    expect_q("rst_retain", 0, 32'h3);
    tick();
    for (int i = 0; i < 4; i++) begin
      a_ra = 12'(i);
      expect_q($sformatf("rst_wr_lane%0d", i), 0, 32'h2);
      tick();
    end

    // Equal-width instruction memory.
    b_wren = 1'b1; b_wa = 8'h10; b_d = 32'h0400_0026; b_ra = 8'h10;
    expect_q("imem_rdw_old", 1, 32'h0);
    tick();
    b_ra = 8'h10;
    expect_q("imem_rd10", 1, 32'h0400_0026);
    tick();
    b_ra = 8'h11;
    expect_q("imem_rd11", 1, 32'h0);
    tick();
    b_wren = 1'b1; b_wa = 8'h12; b_d = 32'h1234_5678; b_ra = 8'h12;
    expect_q("ras_old", 1, 32'h0);
    tick();
    b_ra = 8'h12;
    expect_q("ras_new", 1, 32'h1234_5678);
    tick();

    // Wide-read configuration.
    for (int k = 0; k < 8; k++) begin
      c_wren = 1'b1;
      c_wa = 4'(k);
      c_d = 4'(k + 1);
      tick();
    end
    c_ra = 1'b0;
    expect_q("wide_rd0", 2, 32'h8765_4321);
    tick();
    c_wren = 1'b1; c_wa = 4'h3; c_d = 4'hF; c_ra = 1'b0;
    expect_q("wide_rdw_old", 2, 32'h8765_4321);
    tick();
    c_ra = 1'b0;
    expect_q("wide_rdw_new", 2, 32'h8765_F321);
    tick();
    c_ra = 1'b1;
    expect_q("wide_rd1", 2, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
